// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM byte-lane sequencer.
package wb_sram_pkg;

  localparam int SRAM_AW   = 10;
  localparam int SRAM_DW   = 8;
  localparam int NUM_LANES = 4;

  localparam logic [7:0] WEN_ALL_WR = 8'h00;
  localparam logic [7:0] WEN_ALL_RD = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic slave bus bundle as seen from the caravel wrapper.
interface wb_sram_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_ctrl_lane_pick.sv
// Finds the lowest selected lane (from lane 0 when start, else above cur) and
// flags whether it is the final selected lane.
module lane_pick
  import wb_sram_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  input  logic [1:0]           cur,
  input  logic                 start,
  output logic [1:0]           lane,
  output logic                 last
);

  logic [NUM_LANES-1:0] cand;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_cand
      assign cand[gi] = mask[gi] & (start | (2'(gi) > cur));
    end
  endgenerate

  always_comb begin
    lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (cand[i]) lane = 2'(i);
    end
  end

  // At most one candidate left means the picked lane is the final one.
  assign last = ~|(cand & (cand - 4'd1));

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave that splits each word access into one 8-bit SRAM
// operation per selected byte lane, issued in ascending lane order.
module wb_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SRAM_AW   = 10,
  parameter int          SRAM_DW   = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  wb_sram_ctrl_if.slave      wb,
  output logic               sram_cen_n,
  output logic               sram_gwen_n,
  output logic [SRAM_DW-1:0] sram_wen_n,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [SRAM_DW-1:0] sram_d,
  input  logic [SRAM_DW-1:0] sram_q,
  output logic               busy_o
);
  import wb_sram_pkg::*;

  state_t state_reg, state_next;
  logic [1:0] lane_reg, lane_next, cap_lane_reg, cap_lane_next;
  logic last_reg, last_next, we_reg, we_next, abort_reg, abort_next;
  logic cap_reg, cap_next, ack_reg, ack_next;
  logic [SRAM_AW-3:0] adr_reg, adr_next;
  logic [31:0] dat_reg, dat_next, rdata_reg, rdata_next;
  logic [3:0] sel_reg, sel_next;
  logic cen_reg, cen_next, gwen_reg, gwen_next;
  logic [SRAM_DW-1:0] wen_reg, wen_next, d_reg, d_next;
  logic [SRAM_AW-1:0] a_reg, a_next;

  logic hit, pick_last, iss, iss_we;
  logic [1:0] pick_lane;
  logic [SRAM_AW-3:0] iss_word;
  logic [31:0] iss_data;
  logic unused_adr;

  assign unused_adr = &{1'b0, wb.wbs_adr_i[1:0]};
  assign hit = wb.wbs_cyc_i & wb.wbs_stb_i &
               (wb.wbs_adr_i[31:SRAM_AW] == BASE_ADDR[31:SRAM_AW]);

  lane_pick u_pick (
    .mask  ((state_reg == IDLE) ? wb.wbs_sel_i : sel_reg),
    .cur   (lane_reg),
    .start (state_reg == IDLE),
    .lane  (pick_lane),
    .last  (pick_last)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= IDLE;     lane_reg  <= '0;   last_reg <= 1'b0;
      cap_reg   <= 1'b0;     cap_lane_reg <= '0;
      adr_reg   <= '0;       dat_reg   <= '0;   sel_reg  <= '0;   we_reg <= 1'b0;
      abort_reg <= 1'b0;     ack_reg   <= 1'b0; rdata_reg <= '0;
      cen_reg   <= 1'b1;     gwen_reg  <= 1'b1; wen_reg  <= WEN_ALL_RD;
      a_reg     <= '0;       d_reg     <= '0;
    end else begin
      state_reg <= state_next; lane_reg  <= lane_next; last_reg <= last_next;
      cap_reg   <= cap_next;   cap_lane_reg <= cap_lane_next;
      adr_reg   <= adr_next;   dat_reg   <= dat_next; sel_reg  <= sel_next; we_reg <= we_next;
      abort_reg <= abort_next; ack_reg   <= ack_next; rdata_reg <= rdata_next;
      cen_reg   <= cen_next;   gwen_reg  <= gwen_next; wen_reg <= wen_next;
      a_reg     <= a_next;     d_reg     <= d_next;
    end
  end

  always_comb begin
    state_next = state_reg;  lane_next = lane_reg;  last_next = last_reg;
    cap_next = 1'b0;         cap_lane_next = cap_lane_reg;
    adr_next = adr_reg;      dat_next = dat_reg;    sel_next = sel_reg;  we_next = we_reg;
    abort_next = abort_reg;  rdata_next = rdata_reg;
    cen_next = 1'b1;         gwen_next = 1'b1;      wen_next = WEN_ALL_RD;
    a_next = a_reg;          d_next = d_reg;
    iss = 1'b0;              iss_word = adr_reg;    iss_data = dat_reg;  iss_we = we_reg;

    // A read issued last cycle has its byte on sram_q now.
    if (cap_reg) rdata_next[{cap_lane_reg, 3'b000} +: SRAM_DW] = sram_q;

    case (state_reg)
      IDLE: begin
        abort_next = 1'b0;
        if (hit) begin
          adr_next   = wb.wbs_adr_i[SRAM_AW-1:2];
          dat_next   = wb.wbs_dat_i;
          sel_next   = wb.wbs_sel_i;
          we_next    = wb.wbs_we_i;
          rdata_next = '0;
          if (wb.wbs_sel_i == 4'd0) begin
            state_next = ACK;
          end else begin
            state_next = ISSUE;
            lane_next  = pick_lane;
            last_next  = pick_last;
            iss        = 1'b1;
            iss_word   = wb.wbs_adr_i[SRAM_AW-1:2];
            iss_data   = wb.wbs_dat_i;
            iss_we     = wb.wbs_we_i;
          end
        end
      end
      ISSUE: begin
        abort_next    = abort_reg | ~wb.wbs_cyc_i;
        cap_next      = ~we_reg;
        cap_lane_next = lane_reg;
        if (last_reg) begin
          state_next = we_reg ? ACK : DRAIN;
        end else begin
          lane_next = pick_lane;
          last_next = pick_last;
          iss       = 1'b1;
        end
      end
      DRAIN: begin
        abort_next = abort_reg | ~wb.wbs_cyc_i;
        state_next = ACK;
      end
      default: state_next = IDLE;
    endcase

    if (iss) begin
      cen_next = 1'b0;
      a_next   = {iss_word, pick_lane};
      if (iss_we) begin
        gwen_next = 1'b0;
        wen_next  = WEN_ALL_WR;
        d_next    = lane_byte(iss_data, pick_lane);
      end
    end

    ack_next = (state_next == ACK) && !abort_next;
  end

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = rdata_reg;
  assign sram_cen_n   = cen_reg;
  assign sram_gwen_n  = gwen_reg;
  assign sram_wen_n   = wen_reg;
  assign sram_a       = a_reg;
  assign sram_d       = d_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl with a behavioural 1024x8 SRAM macro.
module tb_wb_sram_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_sram_ctrl_if wb();

  logic       sram_cen_n, sram_gwen_n, busy;
  logic [7:0] sram_wen_n, sram_d, sram_q;
  logic [9:0] sram_a;

  wb_sram_ctrl #(.BASE_ADDR(BASE), .SRAM_AW(10), .SRAM_DW(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .wb          (wb),
    .sram_cen_n  (sram_cen_n),
    .sram_gwen_n (sram_gwen_n),
    .sram_wen_n  (sram_wen_n),
    .sram_a      (sram_a),
    .sram_d      (sram_d),
    .sram_q      (sram_q),
    .busy_o      (busy)
  );

  // Macro model: write on the edge, read data appears the cycle after.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (!sram_cen_n) begin
      if (!sram_gwen_n) mem[sram_a] <= (mem[sram_a] & sram_wen_n) | (sram_d & ~sram_wen_n);
      else              sram_q <= mem[sram_a];
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  logic [9:0]  op_a   [16];
  logic [7:0]  op_d   [16];
  logic        op_wr  [16];
  int          op_cyc [16];
  int          n_ops;
  int          ack_k  [4];
  logic [31:0] ack_dat[4];
  int          n_acks;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          exp_ack;
    int          exp_ops;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input int k);
    if (!sram_cen_n && n_ops < 16) begin
      op_a[n_ops]   = sram_a;
      op_d[n_ops]   = sram_d;
      op_wr[n_ops]  = ~sram_gwen_n;
      op_cyc[n_ops] = k;
      n_ops++;
    end
    if (wb.wbs_ack_o && n_acks < 4) begin
      ack_k[n_acks]   = k;
      ack_dat[n_acks] = wb.wbs_dat_o;
      n_acks++;
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_sel_i = sel;  wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;
  endtask

  task automatic release_bus();
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
  endtask

  // Request launched in cycle 0; outputs observed mid-cycle for cycles 1..9.
  task automatic run_req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
    n_ops = 0; n_acks = 0; ack_k[0] = -1; ack_dat[0] = 32'h0;
    @(posedge clk); #1;
    drive(we, sel, adr, dat);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(k);
      if (wb.wbs_ack_o) release_bus();
    end
    release_bus();
    $display("[TB] txn we=%0d sel=%h adr=%h dat=%h ack_cyc=%0d acks=%0d ops=%0d rdat=%h",
             we, sel, adr, dat, ack_k[0], n_acks, n_ops, ack_dat[0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   {31'd0, wb.wbs_ack_o}, 32'd0);
    check({tag, "_dat"},   wb.wbs_dat_o, 32'd0);
    check({tag, "_cen"},   {31'd0, sram_cen_n}, 32'd1);
    check({tag, "_gwen"},  {31'd0, sram_gwen_n}, 32'd1);
    check({tag, "_wen"},   {24'd0, sram_wen_n}, 32'hFF);
    check({tag, "_a"},     {22'd0, sram_a}, 32'd0);
    check({tag, "_d"},     {24'd0, sram_d}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic busy5, busy6;

  initial begin
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;

    vecs[0]  = '{1'b0, 4'hF, BASE + 32'h010, 32'h0,        6, 4, 32'hA1B2C3D4};
    vecs[1]  = '{1'b0, 4'hF, BASE + 32'h3FC, 32'h0,        6, 4, 32'hDE22BE44};
    vecs[2]  = '{1'b0, 4'h6, BASE + 32'h010, 32'h0,        4, 2, 32'h00B2C300};
    vecs[3]  = '{1'b0, 4'h1, BASE + 32'h3FF, 32'h0,        3, 1, 32'h00000044};
    vecs[4]  = '{1'b1, 4'h0, BASE + 32'h010, 32'hFFFFFFFF, 1, 0, 32'h0};
    vecs[5]  = '{1'b0, 4'h0, BASE + 32'h010, 32'h0,        1, 0, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, BASE + 32'h000, 32'h01020304, 5, 4, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, BASE + 32'h400, 32'hFFFFFFFF, -1, 0, 32'h0};
    vecs[8]  = '{1'b1, 4'hF, 32'h2000_0000,  32'hFFFFFFFF, -1, 0, 32'h0};
    vecs[9]  = '{1'b0, 4'hF, BASE + 32'h000, 32'h0,        6, 4, 32'h01020304};
    vecs[10] = '{1'b1, 4'hF, BASE + 32'h023, 32'h55667788, 5, 4, 32'h0};
    vecs[11] = '{1'b0, 4'hC, BASE + 32'h020, 32'h0,        4, 2, 32'h55660000};
    vecs[12] = '{1'b0, 4'hF, BASE + 32'h800, 32'h0,        -1, 0, 32'h0};
    vecs[13] = '{1'b1, 4'h3, BASE + 32'h020, 32'hAABBCCDD, 3, 2, 32'h0};
    vecs[14] = '{1'b0, 4'hF, BASE + 32'h020, 32'h0,        6, 4, 32'h5566CCDD};
    vecs[15] = '{1'b0, 4'h8, BASE + 32'h3FC, 32'h0,        3, 1, 32'hDE000000};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full write: four lane writes in cycles 1-4, ack in cycle 5.
    run_req(1'b1, 4'hF, BASE + 32'h010, 32'hA1B2C3D4);
    check("wr4_ack_cyc", ack_k[0], 5);
    check("wr4_nops", n_ops, 4);
    begin
      logic [7:0] exp_b [4];
      exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("wr4_a%0d", i), {22'd0, op_a[i]}, 32'h010 + i);
        check($sformatf("wr4_d%0d", i), {24'd0, op_d[i]}, {24'd0, exp_b[i]});
        check($sformatf("wr4_cyc%0d", i), op_cyc[i], i + 1);
        check($sformatf("wr4_we%0d", i), {31'd0, op_wr[i]}, 32'd1);
      end
    end

    // Prefill then partial write at the top of the window.
    run_req(1'b1, 4'hF, BASE + 32'h3FC, 32'hDEADBEEF);
    check("prefill_ack_cyc", ack_k[0], 5);
    run_req(1'b1, 4'h5, BASE + 32'h3FC, 32'h11223344);
    check("part_ack_cyc", ack_k[0], 3);
    check("part_nops", n_ops, 2);
    check("part_a0", {22'd0, op_a[0]}, 32'h3FC);
    check("part_d0", {24'd0, op_d[0]}, 32'h44);
    check("part_a1", {22'd0, op_a[1]}, 32'h3FE);
    check("part_d1", {24'd0, op_d[1]}, 32'h22);

    // Single upper-lane read.
    run_req(1'b0, 4'h8, BASE + 32'h010, 32'h0);
    check("rd1_ack_cyc", ack_k[0], 3);
    check("rd1_nops", n_ops, 1);
    check("rd1_a", {22'd0, op_a[0]}, 32'h013);
    check("rd1_is_read", {31'd0, op_wr[0]}, 32'd0);
    check("rd1_dat", ack_dat[0], 32'hA1000000);

    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
      check($sformatf("v%0d_ack_cyc", i), ack_k[0], vecs[i].exp_ack);
      check($sformatf("v%0d_nacks", i), n_acks, (vecs[i].exp_ack < 0) ? 0 : 1);
      check($sformatf("v%0d_nops", i), n_ops, vecs[i].exp_ops);
      if (!vecs[i].we && vecs[i].exp_ack > 0)
        check($sformatf("v%0d_rdat", i), ack_dat[0], vecs[i].exp_rd);
    end

    // Back-to-back writes with cyc held: second accepted the cycle after ack.
    n_ops = 0; n_acks = 0; ack_k[1] = -1;
    @(posedge clk); #1;
    drive(1'b1, 4'hF, BASE + 32'h040, 32'h0BADCAFE);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(k);
      if (wb.wbs_ack_o && n_acks == 1) begin
        wb.wbs_adr_i = BASE + 32'h044;
        wb.wbs_dat_i = 32'h600DF00D;
      end else if (wb.wbs_ack_o && n_acks == 2) begin
        release_bus();
      end
    end
    release_bus();
    $display("[TB] txn back-to-back acks=%0d ack0=%0d ack1=%0d ops=%0d", n_acks, ack_k[0], ack_k[1], n_ops);
    check("b2b_nacks", n_acks, 2);
    check("b2b_ack0_cyc", ack_k[0], 5);
    check("b2b_ack1_cyc", ack_k[1], 11);
    check("b2b_nops", n_ops, 8);
    check("b2b_op4_a", {22'd0, op_a[4]}, 32'h044);
    check("b2b_op4_cyc", op_cyc[4], 7);
    run_req(1'b0, 4'hF, BASE + 32'h044, 32'h0);
    check("b2b_rd1", ack_dat[0], 32'h600DF00D);
    run_req(1'b0, 4'hF, BASE + 32'h040, 32'h0);
    check("b2b_rd0", ack_dat[0], 32'h0BADCAFE);

    // Abort: cyc dropped in cycle 2 of a four-lane write.
    n_ops = 0; n_acks = 0; busy5 = 1'b0; busy6 = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 4'hF, BASE + 32'h080, 32'hCAFEF00D);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      if (k == 2) begin #1; release_bus(); end
      @(negedge clk);
      sample(k);
      if (k == 5) busy5 = busy;
      if (k == 6) busy6 = busy;
    end
    $display("[TB] txn abort acks=%0d ops=%0d busy5=%0d busy6=%0d", n_acks, n_ops, busy5, busy6);
    check("abort_nacks", n_acks, 0);
    check("abort_nops", n_ops, 4);
    check("abort_busy5", {31'd0, busy5}, 32'd1);
    check("abort_busy6", {31'd0, busy6}, 32'd0);
    run_req(1'b0, 4'hF, BASE + 32'h080, 32'h0);
    check("abort_rd_ack_cyc", ack_k[0], 6);
    check("abort_rd_dat", ack_dat[0], 32'hCAFEF00D);

    // Asynchronous reset in the middle of ISSUE.
    @(posedge clk); #1;
    drive(1'b1, 4'hF, BASE + 32'h0C0, 32'h99999999);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_issue_cen", {31'd0, sram_cen_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    release_bus();
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] txn reset mid-issue released");
    run_req(1'b1, 4'hF, BASE + 32'h0C0, 32'h12345678);
    check("post_rst_wr_ack_cyc", ack_k[0], 5);
    check("post_rst_wr_nops", n_ops, 4);
    run_req(1'b0, 4'hF, BASE + 32'h0C0, 32'h0);
    check("post_rst_rd_ack_cyc", ack_k[0], 6);
    check("post_rst_rd_dat", ack_dat[0], 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
